// File: rtl/pcie_tl_pkg.sv
// Shared definitions for the PCIe TL round-robin crossbar: FSM encodings and a
// width helper used for parameter-derived widths.
package pcie_tl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pcie_tl_fifo.sv
// Single-clock FIFO with occupancy-based almost-full/almost-empty flags and
// overflow/underflow strobes; a rejected access leaves the contents untouched.
module pcie_tl_fifo import pcie_tl_pkg::*; #(
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  input  logic [AW:0]   low_thr,
  input  logic [AW:0]   high_thr,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          alm_full,
  output logic          alm_empty,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   occ;
  logic          full, wr_ok, rd_ok;

  assign empty = (occ == '0);
  assign full  = (occ == FULL_OCC);
  // A pop on a full FIFO still frees a slot, but the push that cycle is dropped.
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;
  assign ovf   = push && full;
  assign udf   = pop && empty;

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= din;

  always_ff @(posedge clk)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

  assign dout      = empty ? '0 : mem[rd_ptr];
  assign alm_full  = (occ >= high_thr);
  assign alm_empty = (occ <= low_thr);

endmodule

// File: rtl/pcie_tl_rr.sv
// NCH-input / NCH-output crossbar: round-robin arbiter pops one input word per
// cycle into an in-flight register, which is routed to its destination FIFO.
module pcie_tl_rr import pcie_tl_pkg::*; #(
  parameter int NCH   = 4,
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  parameter int CW    = 5,
  localparam int LW   = clog2(NCH),
  localparam int TW   = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [TW-1:0]     low_thr,
  input  logic [TW-1:0]     high_thr,
  input  logic [NCH-1:0]    push_in,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH-1:0]    pop_out,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    alm_full_in,
  output logic [NCH-1:0]    empty_out,
  input  logic              req,
  input  logic [LW-1:0]     idx,
  output logic [CW-1:0]     cnt,
  output logic              valid,
  output logic [2:0]        state,
  output logic              err
);

  state_t state_q, state_d;

  logic [NCH-1:0][DW-1:0] in_word, in_head, out_head;
  logic [NCH-1:0][LW-1:0] in_dest;
  logic [NCH-1:0]         in_empty, in_ae, in_pop, in_ovf, in_udf;
  logic [NCH-1:0]         out_push, out_empty, out_af, out_ae, out_ovf, out_udf;
  logic [NCH-1:0]         elig;
  logic [NCH-1:0][CW-1:0] ctr;

  logic [TW-1:0] lo_q, hi_q;
  logic [LW-1:0] ptr, win, fly_dest;
  logic [DW-1:0] fly_word;
  logic          fly_vld, found, any_err, all_idle;
  logic          unused_ae;

  assign in_word   = data_in;
  assign data_out  = out_head;
  assign empty_out = out_empty;
  assign fly_dest  = fly_word[DW-1 -: LW];
  assign unused_ae = ^{in_ae, out_ae};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pcie_tl_fifo #(.DW(DW), .DEPTH(DEPTH)) u_in (
      .clk, .reset,
      .push(push_in[i]), .pop(in_pop[i]), .din(in_word[i]),
      .low_thr(lo_q), .high_thr(hi_q),
      .dout(in_head[i]), .empty(in_empty[i]), .alm_full(alm_full_in[i]),
      .alm_empty(in_ae[i]), .ovf(in_ovf[i]), .udf(in_udf[i])
    );

    pcie_tl_fifo #(.DW(DW), .DEPTH(DEPTH)) u_out (
      .clk, .reset,
      .push(out_push[i]), .pop(pop_out[i]), .din(fly_word),
      .low_thr(lo_q), .high_thr(hi_q),
      .dout(out_head[i]), .empty(out_empty[i]), .alm_full(out_af[i]),
      .alm_empty(out_ae[i]), .ovf(out_ovf[i]), .udf(out_udf[i])
    );

    assign in_dest[i]  = in_head[i][DW-1 -: LW];
    // Almost-full does not yet count the in-flight word, so its target is blocked too.
    assign elig[i]     = !in_empty[i] && !out_af[in_dest[i]] &&
                         !(fly_vld && (fly_dest == in_dest[i]));
    assign in_pop[i]   = found && (win == LW'(i));
    assign out_push[i] = fly_vld && (fly_dest == LW'(i));
  end

  always_comb begin
    logic [LW-1:0] cand;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    if (state_q == ST_ACTIVE)
      for (int k = 0; k < NCH; k++) begin
        cand = ptr + LW'(k);
        if (!found && elig[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
  end

  always_ff @(posedge clk)
    if (reset) begin
      ptr      <= '0;
      fly_vld  <= 1'b0;
      fly_word <= '0;
    end else begin
      fly_vld <= found;
      if (found) begin
        fly_word <= in_head[win];
        ptr      <= win + LW'(1);
      end
    end

  assign any_err  = |{in_ovf, in_udf, out_ovf, out_udf};
  // A word still in flight keeps the block ACTIVE until it lands and drains.
  assign all_idle = (&in_empty) && (&out_empty) && !fly_vld;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (init) state_d = ST_INIT;
                 else if (!(&in_empty)) state_d = ST_ACTIVE;
      ST_ACTIVE: if (init) state_d = ST_INIT;
                 else if (all_idle) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
    if (any_err) state_d = ST_ERROR;
  end

  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ST_RESET;
      err     <= 1'b0;
      lo_q    <= TW'(1);
      hi_q    <= TW'(DEPTH - 1);
    end else begin
      state_q <= state_d;
      err     <= err | any_err;
      if (state_q == ST_INIT && init) begin
        lo_q <= low_thr;
        hi_q <= high_thr;
      end
    end

  assign state = state_q;

  always_ff @(posedge clk)
    if (reset) ctr <= '0;
    else
      for (int i = 0; i < NCH; i++)
        if (pop_out[i] && !out_empty[i]) ctr[i] <= ctr[i] + CW'(1);

  // Registered read naturally returns the pre-increment value on a same-cycle pop.
  always_ff @(posedge clk)
    if (reset) begin
      cnt   <= '0;
      valid <= 1'b0;
    end else if (req && (state_q == ST_IDLE || state_q == ST_ACTIVE)) begin
      cnt   <= ctr[idx];
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end

endmodule

// File: tb/tb_pcie_tl_rr.sv
// Directed bench for pcie_tl_rr: threshold load, routing latency, round-robin
// order, backpressure, overflow error and the per-output pop counters.
module tb_pcie_tl_rr;
  localparam int NCH = 4, DW = 10, DEPTH = 8, CW = 5, LW = 2, TW = 4;

  logic              clk = 1'b0;
  logic              reset, init, req, valid, err;
  logic [TW-1:0]     low_thr, high_thr;
  logic [NCH-1:0]    push_in, pop_out, alm_full_in, empty_out;
  logic [NCH*DW-1:0] data_in, data_out;
  logic [LW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [2:0]        state;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pcie_tl_rr #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .init(init), .low_thr(low_thr), .high_thr(high_thr),
    .push_in(push_in), .data_in(data_in), .pop_out(pop_out), .data_out(data_out),
    .alm_full_in(alm_full_in), .empty_out(empty_out), .req(req), .idx(idx),
    .cnt(cnt), .valid(valid), .state(state), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] head(input int j);
    return data_out[j*DW +: DW];
  endfunction

  task automatic put(input int i, input logic [DW-1:0] w);
    data_in[i*DW +: DW] = w;
  endtask

  task automatic do_reset(input logic [TW-1:0] lo, input logic [TW-1:0] hi);
    reset = 1'b1; init = 1'b0; push_in = '0; pop_out = '0; req = 1'b0; idx = '0;
    data_in = '0; low_thr = lo; high_thr = hi;
    tick(); tick();
    reset = 1'b0; init = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick();
  endtask

  // Stream n words src->dst, popping dst whenever it holds data.
  task automatic xfer(input int src, input int dst, input int n);
    int pushed = 0, popped = 0, cyc = 0;
    while (popped < n && cyc < 10*n + 20) begin
      push_in = '0; pop_out = '0;
      if (pushed < n && cyc % 2 == 0) begin
        push_in[src] = 1'b1;
        put(src, {LW'(dst), 8'(pushed)});
        pushed++;
      end
      if (!empty_out[dst]) begin
        pop_out[dst] = 1'b1;
        popped++;
      end
      tick();
      cyc++;
    end
    push_in = '0; pop_out = '0;
    chk("xfer_done", popped, n);
  endtask

  task automatic wait_head(input int j);
    int cyc = 0;
    while (empty_out[j] && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("wait_head", !empty_out[j], 1);
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int cyc;

    // Reset state and threshold load
    reset = 1'b1; init = 1'b0; push_in = '0; pop_out = '0; req = 1'b0; idx = '0;
    data_in = '0; low_thr = 4'd1; high_thr = 4'd7;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_empty", empty_out, 4'hF);
    chk("rst_af", alm_full_in, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    reset = 1'b0; init = 1'b1; low_thr = 4'd2; high_thr = 4'd6;
    tick();
    chk("init_state", state, 1);
    tick();
    for (int k = 0; k < 6; k++) begin
      push_in = 4'b0001;
      put(0, {2'b01, 8'(k)});
      tick();
      chk($sformatf("af_push%0d", k + 1), alm_full_in[0], k == 5);
    end
    push_in = '0; init = 1'b0;
    tick();
    chk("idle_state", state, 2);
    tick();
    chk("active_state", state, 3);

    // Routing: 0x2A5 on input 1 lands on output 2
    do_reset(4'd1, 4'd7);
    put(1, 10'h2A5); push_in = 4'b0010;
    tick();
    push_in = '0;
    chk("rt_idle", state, 2);
    tick();
    chk("rt_active", state, 3);
    tick();
    chk("rt_pop_cycle", empty_out, 4'hF);
    tick();
    chk("rt_head", head(2), 10'h2A5);
    chk("rt_empty", empty_out, 4'b1011);
    chk("rt_still_active", state, 3);
    pop_out = 4'b0100;
    tick();
    pop_out = '0;
    chk("rt_drained", empty_out, 4'hF);
    tick();
    chk("rt_back_idle", state, 2);
    chk("rt_err", err, 0);

    // Fairness: 3 words per input, input i targets output i
    do_reset(4'd1, 4'd7);
    for (int w = 0; w < 3; w++) begin
      push_in = '1;
      for (int i = 0; i < NCH; i++) put(i, {LW'(i), 4'h0, 2'(w), 2'(i)});
      tick();
    end
    push_in = '0;
    cyc = 0;
    while (got.size() < 12 && cyc < 100) begin
      pop_out = ~empty_out;
      for (int j = 0; j < NCH; j++)
        if (!empty_out[j]) got.push_back(head(j));
      tick();
      cyc++;
    end
    pop_out = '0;
    chk("rr_count", got.size(), 12);
    for (int k = 0; k < got.size() && k < 12; k++)
      chk($sformatf("rr_order%0d", k), got[k], {2'(k % 4), 4'h0, 2'(k / 4), 2'(k % 4)});
    chk("rr_err", err, 0);

    // Backpressure with high_thr=2: output 3 full of input-2 traffic
    do_reset(4'd1, 4'd2);
    put(2, 10'h320); push_in = 4'b0100;
    tick();
    put(2, 10'h321);
    tick();
    push_in = '0;
    repeat (8) tick();
    chk("bp_out3_af", empty_out, 4'b0111);
    chk("bp_in_clear", alm_full_in, 0);
    put(0, 10'h301); put(1, 10'h011); push_in = 4'b0011;
    tick();
    put(0, 10'h302); put(1, 10'h012);
    tick();
    push_in = '0;
    repeat (10) tick();
    chk("bp_in0_held", alm_full_in, 4'b0001);
    chk("bp_empty", empty_out, 4'b0110);
    chk("bp_out0_head", head(0), 10'h011);
    chk("bp_out3_head", head(3), 10'h320);
    pop_out = 4'b1000;
    tick(); tick();
    pop_out = '0;
    repeat (8) tick();
    chk("bp_resume_af", alm_full_in, 0);
    chk("bp_resume_head", head(3), 10'h301);
    chk("bp_resume_empty", empty_out, 4'b0110);
    chk("bp_err", err, 0);

    // Overflow: 9 pushes while held in INIT (no draining)
    do_reset(4'd1, 4'd7);
    init = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      push_in = 4'b0001;
      put(0, 10'(k));
      tick();
      if (k == 7) begin
        chk("ovf_pre_err", err, 0);
        chk("ovf_full_af", alm_full_in[0], 1);
        chk("ovf_pre_state", state, 1);
      end
    end
    push_in = '0; init = 1'b0;
    chk("ovf_err", err, 1);
    chk("ovf_state", state, 4);
    repeat (3) tick();
    chk("ovf_err_held", err, 1);
    chk("ovf_state_held", state, 4);
    req = 1'b1; idx = 2'd0;
    tick();
    req = 1'b0;
    chk("ovf_no_valid", valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovf_rst_state", state, 0);
    chk("ovf_rst_err", err, 0);

    // Counters
    do_reset(4'd1, 4'd7);
    xfer(0, 1, 5);
    req = 1'b1; idx = 2'd2;
    tick();
    chk("cnt2_zero", cnt, 0);
    idx = 2'd1;
    tick();
    chk("cnt1_five", cnt, 5);
    chk("cnt_valid", valid, 1);
    req = 1'b0;
    tick();
    chk("cnt_valid_drop", valid, 0);
    chk("cnt_hold", cnt, 5);
    put(0, {2'b01, 8'hAA}); push_in = 4'b0001;
    tick();
    push_in = '0;
    wait_head(1);
    pop_out = 4'b0010; req = 1'b1; idx = 2'd1;
    tick();
    pop_out = '0;
    chk("cnt_pre_inc", cnt, 5);
    tick();
    req = 1'b0;
    chk("cnt_post_inc", cnt, 6);
    xfer(0, 1, 27);
    req = 1'b1; idx = 2'd1;
    tick();
    req = 1'b0;
    chk("cnt_wrap", cnt, 1);
    chk("cnt_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
